// File: rtl/vec_alu_dispatch.sv
// ---------------------------------------------------------------------------
// vec_alu_dispatch
//
// Sequencer between vector decode and the vec_alu lane array / vector
// register file. Accepts one arithmetic command at a time. For each register
// of the LMUL group it reads vs2 (and vs1 for VV) from the VRF, runs all
// lanes, waits until every lane reports done, OR-merges the lane results and
// writes the merged value to vd. A command that cannot be executed is
// answered with resp_err one cycle after acceptance, without touching the
// VRF or the lanes.
//
// Parameters
//   VLEN         vector register width in bits (>= 64)
//   NLANES_LOG2  log2 of the number of lanes; NLANES = 1 << NLANES_LOG2
//
// Ports
//   clk, resetn                     clock, synchronous active-low reset
//   req_valid / req_ready           command handshake (ready only when idle)
//   req_opcode                      funct6: vadd 000000, vand 001001,
//                                   vor 001010, vxor 001011
//   req_op_type                     one-hot: 001 VV, 010 VX, 100 VI
//   req_vsew                        element width code 0..3 (8..64 bits)
//   req_vlmul                       0..3 = group of 1/2/4/8, 1xx = group 1
//   req_vd / req_vs1 / req_vs2      register numbers
//   req_scalar                      rs1 value (VX) or immediate in [4:0] (VI)
//   resp_valid / resp_err           one-cycle completion pulse and error flag
//   rd_en / rd_addr / rd_data       VRF read port, data one cycle after rd_en
//   wr_en / wr_addr / wr_data       VRF write port, one-cycle pulse
//   alu_run                         lane run; lanes clear their state when low
//   alu_opcode/alu_op_type/alu_vsew lane controls, stable while alu_run is high
//   alu_nb_lanes                    constant NLANES_LOG2
//   alu_vs1 / alu_vs2               lane operands (scalar in [63:0] for VX/VI)
//   alu_done / alu_vd               per-lane done flags and results
//
// Build option
//   VEC_DISPATCH_FWD_EN : when defined, a read issued right after a write to
//   the same register takes the last written data instead of rd_data, so the
//   VRF may be read-before-write. When undefined the VRF must be write-first.
// ---------------------------------------------------------------------------
module vec_alu_dispatch #(
    parameter int VLEN        = 128,
    parameter int NLANES_LOG2 = 2
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [5:0]                           req_opcode,
    input  logic [2:0]                           req_op_type,
    input  logic [2:0]                           req_vsew,
    input  logic [2:0]                           req_vlmul,
    input  logic [4:0]                           req_vd,
    input  logic [4:0]                           req_vs1,
    input  logic [4:0]                           req_vs2,
    input  logic [63:0]                          req_scalar,
    output logic                                 resp_valid,
    output logic                                 resp_err,
    output logic                                 rd_en,
    output logic [4:0]                           rd_addr,
    input  logic [VLEN-1:0]                      rd_data,
    output logic                                 wr_en,
    output logic [4:0]                           wr_addr,
    output logic [VLEN-1:0]                      wr_data,
    output logic                                 alu_run,
    output logic [5:0]                           alu_opcode,
    output logic [2:0]                           alu_op_type,
    output logic [2:0]                           alu_vsew,
    output logic [1:0]                           alu_nb_lanes,
    output logic [VLEN-1:0]                      alu_vs1,
    output logic [VLEN-1:0]                      alu_vs2,
    input  logic [(1<<NLANES_LOG2)-1:0]          alu_done,
    input  logic [(1<<NLANES_LOG2)*VLEN-1:0]     alu_vd
);

    localparam int NLANES = 1 << NLANES_LOG2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_RD2  = 3'd2,
        S_RD1  = 3'd3,
        S_LAT1 = 3'd4,
        S_EXEC = 3'd5,
        S_WB   = 3'd6
    } state_t;

    state_t      state_r;
    logic [4:0]  vd_r;
    logic [4:0]  vs1_r;
    logic [4:0]  vs2_r;
    logic        is_vv_r;
    logic [63:0] scalar_r;
    logic [2:0]  last_idx_r;
    logic [2:0]  idx_r;

    logic [4:0]      grp_mask_s;
    logic [2:0]      last_idx_s;
    logic            op_ok_s;
    logic            type_ok_s;
    logic            align_ok_s;
    logic            req_err_s;
    logic [63:0]     scalar_ext_s;
    logic [2:0]      idx_nxt_s;
    logic [4:0]      vs2_addr_s;
    logic [4:0]      vs1_addr_s;
    logic [4:0]      vd_addr_s;
    logic [4:0]      vs2_next_addr_s;
    logic [VLEN-1:0] rd2_data_s;
    logic [VLEN-1:0] rd1_data_s;

    // OR of all lane result slices; each lane only drives its own elements.
    function automatic logic [VLEN-1:0] or_merge(input logic [NLANES*VLEN-1:0] lanes);
        logic [VLEN-1:0] acc;
        acc = {VLEN{1'b0}};
        for (int k = 0; k < NLANES; k++) begin
            acc = acc | lanes[k*VLEN +: VLEN];
        end
        return acc;
    endfunction

    assign alu_nb_lanes = 2'(NLANES_LOG2);

    // Group size decode and command legality checks on the incoming request.
    always_comb begin
        case (req_vlmul)
            3'b000:  begin grp_mask_s = 5'd0; last_idx_s = 3'd0; end
            3'b001:  begin grp_mask_s = 5'd1; last_idx_s = 3'd1; end
            3'b010:  begin grp_mask_s = 5'd3; last_idx_s = 3'd3; end
            3'b011:  begin grp_mask_s = 5'd7; last_idx_s = 3'd7; end
            default: begin grp_mask_s = 5'd0; last_idx_s = 3'd0; end
        endcase

        case (req_opcode)
            6'b000000: op_ok_s = 1'b1;
            6'b001001: op_ok_s = 1'b1;
            6'b001010: op_ok_s = 1'b1;
            6'b001011: op_ok_s = 1'b1;
            default:   op_ok_s = 1'b0;
        endcase

        type_ok_s = (req_op_type == 3'b001) || (req_op_type == 3'b010) ||
                    (req_op_type == 3'b100);

        // vs1 is only a register operand for VV; for VX/VI it is don't-care.
        if (req_op_type == 3'b001) begin
            align_ok_s = ((req_vd & grp_mask_s) == 5'd0) && ((req_vs2 & grp_mask_s) == 5'd0) &&
                         ((req_vs1 & grp_mask_s) == 5'd0);
        end else begin
            align_ok_s = ((req_vd & grp_mask_s) == 5'd0) && ((req_vs2 & grp_mask_s) == 5'd0);
        end

        req_err_s = (req_vsew > 3'd3) || !op_ok_s || !type_ok_s || !align_ok_s;

        // VI immediate is 5-bit signed; VX scalar is passed as given.
        if (req_op_type == 3'b100) begin
            scalar_ext_s = {{59{req_scalar[4]}}, req_scalar[4:0]};
        end else begin
            scalar_ext_s = req_scalar;
        end
    end

    // Per-register addresses inside the group, wrapping at 32 registers.
    always_comb begin
        idx_nxt_s       = idx_r + 3'd1;
        vs2_addr_s      = vs2_r + {2'b00, idx_r};
        vs1_addr_s      = vs1_r + {2'b00, idx_r};
        vd_addr_s       = vd_r + {2'b00, idx_r};
        vs2_next_addr_s = vs2_r + {2'b00, idx_nxt_s};
    end

`ifdef VEC_DISPATCH_FWD_EN
    logic fwd_vld_r;

    // Marks that the previous cycle was a write-back of this command, so the
    // reads that follow may hit the register just written (kept in wr_addr/wr_data).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fwd_vld_r <= 1'b0;
        end else if (state_r == S_WB) begin
            fwd_vld_r <= (idx_r != last_idx_r);
        end else if ((state_r == S_EXEC) || (state_r == S_IDLE)) begin
            fwd_vld_r <= 1'b0;
        end else begin
            fwd_vld_r <= fwd_vld_r;
        end
    end

    // Substitute the last written value when the read targets that register.
    always_comb begin
        if (fwd_vld_r && (wr_addr == vs2_addr_s)) begin
            rd2_data_s = wr_data;
        end else begin
            rd2_data_s = rd_data;
        end
        if (fwd_vld_r && (wr_addr == vs1_addr_s)) begin
            rd1_data_s = wr_data;
        end else begin
            rd1_data_s = rd_data;
        end
    end
`else
    // Write-first VRF: read data is always current.
    always_comb begin
        rd2_data_s = rd_data;
        rd1_data_s = rd_data;
    end
`endif

    // Command sequencer: state, latched command fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= S_IDLE;
            vd_r        <= 5'd0;
            vs1_r       <= 5'd0;
            vs2_r       <= 5'd0;
            is_vv_r     <= 1'b0;
            scalar_r    <= 64'd0;
            last_idx_r  <= 3'd0;
            idx_r       <= 3'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= 5'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 5'd0;
            wr_data     <= {VLEN{1'b0}};
            alu_run     <= 1'b0;
            alu_opcode  <= 6'd0;
            alu_op_type <= 3'd0;
            alu_vsew    <= 3'd0;
            alu_vs1     <= {VLEN{1'b0}};
            alu_vs2     <= {VLEN{1'b0}};
        end else begin
            // Pulsed outputs default low; wr_addr/wr_data keep the last write.
            wr_en      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        idx_r     <= 3'd0;
                        if (req_err_s) begin
                            state_r    <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_r     <= S_RD2;
                            vd_r        <= req_vd;
                            vs1_r       <= req_vs1;
                            vs2_r       <= req_vs2;
                            is_vv_r     <= (req_op_type == 3'b001);
                            scalar_r    <= scalar_ext_s;
                            last_idx_r  <= last_idx_s;
                            alu_opcode  <= req_opcode;
                            alu_op_type <= req_op_type;
                            alu_vsew    <= req_vsew;
                            rd_en       <= 1'b1;
                            rd_addr     <= req_vs2;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_ERR: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                end

                // vs2 read is on the port; issue the vs1 read now so its data
                // arrives while vs2 data is being latched.
                S_RD2: begin
                    state_r <= S_RD1;
                    if (is_vv_r) begin
                        rd_en   <= 1'b1;
                        rd_addr <= vs1_addr_s;
                    end else begin
                        rd_en <= 1'b0;
                    end
                end

                S_RD1: begin
                    alu_vs2 <= rd2_data_s;
                    rd_en   <= 1'b0;
                    if (is_vv_r) begin
                        state_r <= S_LAT1;
                    end else begin
                        alu_vs1 <= {{(VLEN-64){1'b0}}, scalar_r};
                        alu_run <= 1'b1;
                        state_r <= S_EXEC;
                    end
                end

                S_LAT1: begin
                    alu_vs1 <= rd1_data_s;
                    alu_run <= 1'b1;
                    state_r <= S_EXEC;
                end

                // Only a complete set of done flags produces a write.
                S_EXEC: begin
                    if (&alu_done) begin
                        alu_run <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= vd_addr_s;
                        wr_data <= or_merge(alu_vd);
                        state_r <= S_WB;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end

                S_WB: begin
                    if (idx_r == last_idx_r) begin
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        state_r    <= S_IDLE;
                    end else begin
                        idx_r   <= idx_nxt_s;
                        rd_en   <= 1'b1;
                        rd_addr <= vs2_next_addr_s;
                        state_r <= S_RD2;
                    end
                end

                default: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                    rd_en     <= 1'b0;
                    alu_run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_dispatch.sv
module tb_vec_alu_dispatch;

    localparam int VLEN = 128;
    localparam int NL   = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [2:0]        req_op_type;
    logic [2:0]        req_vsew;
    logic [2:0]        req_vlmul;
    logic [4:0]        req_vd;
    logic [4:0]        req_vs1;
    logic [4:0]        req_vs2;
    logic [63:0]       req_scalar;
    logic              resp_valid;
    logic              resp_err;
    logic              rd_en;
    logic [4:0]        rd_addr;
    logic [VLEN-1:0]   rd_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [VLEN-1:0]   wr_data;
    logic              alu_run;
    logic [5:0]        alu_opcode;
    logic [2:0]        alu_op_type;
    logic [2:0]        alu_vsew;
    logic [1:0]        alu_nb_lanes;
    logic [VLEN-1:0]   alu_vs1;
    logic [VLEN-1:0]   alu_vs2;
    logic [NL-1:0]     alu_done;
    logic [NL*VLEN-1:0] alu_vd;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_alu_dispatch #(.VLEN(VLEN), .NLANES_LOG2(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op_type(req_op_type),
        .req_vsew(req_vsew), .req_vlmul(req_vlmul),
        .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_scalar(req_scalar),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_op_type(alu_op_type),
        .alu_vsew(alu_vsew), .alu_nb_lanes(alu_nb_lanes),
        .alu_vs1(alu_vs1), .alu_vs2(alu_vs2),
        .alu_done(alu_done), .alu_vd(alu_vd)
    );

    always #5 clk = ~clk;

    // ---------------- VRF model (write-first seen by next-cycle reads) -----
    logic [VLEN-1:0] vrf [32];
    logic            pre_en;
    logic [4:0]      pre_addr;
    logic [VLEN-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) vrf[pre_addr] <= pre_data;
        else if (wr_en) vrf[wr_addr] <= wr_data;
        if (rd_en) rd_data <= vrf[rd_addr];
    end

    // ---------------- lane array model ----------------------------------
    int lane_delay;
    int lane_cnt = 0;

    // Element-wise op; lane `lane` owns the elements with index % NL == lane.
    function automatic logic [VLEN-1:0] lane_calc(input logic [5:0] op, input logic [2:0] ty,
                                                  input logic [2:0] sew, input logic [VLEN-1:0] a1,
                                                  input logic [VLEN-1:0] a2, input int lane);
        int ew;
        int ne;
        logic [63:0] m, x, y, r;
        logic [VLEN-1:0] res;
        logic [VLEN-1:0] t1, t2;
        ew  = 8 << sew;
        ne  = VLEN / ew;
        m   = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        res = '0;
        for (int e = 0; e < ne; e++) begin
            t2 = a2 >> (e * ew);
            t1 = a1 >> (e * ew);
            x  = t2[63:0] & m;
            y  = (ty == 3'b001) ? (t1[63:0] & m) : (a1[63:0] & m);
            case (op)
                6'b000000: r = x + y;
                6'b001001: r = x & y;
                6'b001010: r = x | y;
                6'b001011: r = x ^ y;
                default:   r = 64'd0;
            endcase
            r = r & m;
            if ((e % NL) == lane) res = res | ({64'd0, r} << (e * ew));
        end
        return res;
    endfunction

    // Lanes finish one cycle apart so partial-done states exist.
    always @(posedge clk) begin
        if (!resetn || !alu_run) begin
            lane_cnt <= 0;
            alu_done <= '0;
            alu_vd   <= '0;
        end else begin
            lane_cnt <= lane_cnt + 1;
            for (int k = 0; k < NL; k++) begin
                if (lane_cnt >= lane_delay + k) begin
                    alu_done[k] <= 1'b1;
                    alu_vd[k*VLEN +: VLEN] <= lane_calc(alu_opcode, alu_op_type, alu_vsew,
                                                        alu_vs1, alu_vs2, k);
                end
            end
        end
    end

    // ---------------- monitor ----------------------------------------------
    logic [4:0]      wr_addr_q [$];
    logic [VLEN-1:0] wr_data_q [$];
    logic [4:0]      rd_addr_q [$];
    int   run_starts = 0;
    int   resp_count = 0;
    logic run_prev   = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(wr_addr);
            wr_data_q.push_back(wr_data);
        end
        if (rd_en) rd_addr_q.push_back(rd_addr);
        if (alu_run && !run_prev) run_starts <= run_starts + 1;
        run_prev <= alu_run;
        if (resp_valid) resp_count <= resp_count + 1;
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic vrf_set(input logic [4:0] a, input logic [VLEN-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [2:0] ty, input logic [2:0] sew,
                        input logic [2:0] lmul, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [63:0] sc);
        @(negedge clk);
        req_opcode = op; req_op_type = ty; req_vsew = sew; req_vlmul = lmul;
        req_vd = vd; req_vs1 = vs1; req_vs2 = vs2; req_scalar = sc;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic got, output logic err);
        got = 1'b0;
        err = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            if (resp_valid) begin
                got = 1'b1;
                err = resp_err;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests -----------------------------------------------------
    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, rd_en, wr_en, alu_run} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {req_ready, resp_valid, resp_err, rd_en, wr_en, alu_run});
        end
        tests_run++;
        if ({rd_addr, wr_addr, alu_opcode, alu_op_type, alu_vsew} !== 22'd0 ||
            alu_vs1 !== '0 || alu_vs2 !== '0 || wr_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: rd_addr=%0d wr_addr=%0d op=%0h vs1=%h", rd_addr, wr_addr,
                     alu_opcode, alu_vs1);
        end
        tests_run++;
        if (alu_nb_lanes !== 2'd2) begin
            tests_failed++;
            $display("FAIL nb_lanes: got %0d want 2", alu_nb_lanes);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vv_vadd;
        int bw, br;
        logic got, err;
        lane_delay = 2;
        vrf_set(5'd2, {16{8'h01}});
        vrf_set(5'd3, {16{8'hFF}});
        bw = wr_addr_q.size(); br = rd_addr_q.size();
        send(6'b000000, 3'b001, 3'b000, 3'b000, 5'd1, 5'd3, 5'd2, 64'd0);
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL vv_busy_ready: got %b want 0", req_ready);
        end
        wait_resp(got, err);
        tests_run++;
        if (got !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL vv_resp: got valid=%b err=%b want 1/0", got, err);
        end
        tests_run++;
        if (wr_addr_q.size() - bw != 1 || wr_addr_q[bw] !== 5'd1 || wr_data_q[bw] !== {16{8'h00}}) begin
            tests_failed++;
            $display("FAIL vv_write: n=%0d addr=%0d data=%h want 1/1/0", wr_addr_q.size() - bw,
                     wr_addr_q[bw], wr_data_q[bw]);
        end
        tests_run++;
        if (rd_addr_q.size() - br != 2 || rd_addr_q[br] !== 5'd2 || rd_addr_q[br+1] !== 5'd3) begin
            tests_failed++;
            $display("FAIL vv_reads: n=%0d first=%0d second=%0d want 2/2/3", rd_addr_q.size() - br,
                     rd_addr_q[br], rd_addr_q[br+1]);
        end
    endtask

    task automatic test_vx_vxor;
        int bw, br;
        logic got, err;
        lane_delay = 1;
        vrf_set(5'd5, {4{32'h12345678}});
        bw = wr_addr_q.size(); br = rd_addr_q.size();
        send(6'b001011, 3'b010, 3'b010, 3'b000, 5'd6, 5'd31, 5'd5, 64'h0000_0000_FFFF_0000);
        wait_resp(got, err);
        tests_run++;
        if (got !== 1'b1 || err !== 1'b0 || wr_addr_q.size() - bw != 1 || wr_addr_q[bw] !== 5'd6 ||
            wr_data_q[bw] !== {4{32'hEDCB5678}}) begin
            tests_failed++;
            $display("FAIL vx_vxor: resp=%b/%b addr=%0d data=%h want addr 6 data %h", got, err,
                     wr_addr_q[bw], wr_data_q[bw], {4{32'hEDCB5678}});
        end
        tests_run++;
        if (rd_addr_q.size() - br != 1 || rd_addr_q[br] !== 5'd5) begin
            tests_failed++;
            $display("FAIL vx_reads: n=%0d first=%0d want 1/5", rd_addr_q.size() - br, rd_addr_q[br]);
        end
    endtask

    // Fractional vlmul (1xx) is a group of one, so vd=9 is legal.
    task automatic test_vi_vand;
        int bw, br;
        logic got, err;
        lane_delay = 3;
        vrf_set(5'd7, {2{64'h7F}});
        bw = wr_addr_q.size(); br = rd_addr_q.size();
        send(6'b001001, 3'b100, 3'b011, 3'b101, 5'd9, 5'd0, 5'd7, 64'h10);
        wait_resp(got, err);
        tests_run++;
        if (got !== 1'b1 || err !== 1'b0 || wr_addr_q.size() - bw != 1 || wr_addr_q[bw] !== 5'd9 ||
            wr_data_q[bw] !== {2{64'h70}}) begin
            tests_failed++;
            $display("FAIL vi_vand: resp=%b/%b n=%0d addr=%0d data=%h want 9/%h", got, err,
                     wr_addr_q.size() - bw, wr_addr_q[bw], wr_data_q[bw], {2{64'h70}});
        end
        tests_run++;
        if (rd_addr_q.size() - br != 1 || rd_addr_q[br] !== 5'd7) begin
            tests_failed++;
            $display("FAIL vi_reads: n=%0d first=%0d want 1/7", rd_addr_q.size() - br, rd_addr_q[br]);
        end
    endtask

    task automatic test_lmul4;
        int bw, br;
        logic got, err;
        logic [7:0] b2, b1, exp_b;
        logic [7:0] exp_t [4];
        exp_t = '{8'h11, 8'h22, 8'h44, 8'h88};
        lane_delay = 0;
        for (int k = 0; k < 4; k++) begin
            b2 = 8'h01 << k;
            b1 = 8'h10 << k;
            vrf_set(5'(8 + k), {16{b2}});
            vrf_set(5'(12 + k), {16{b1}});
        end
        bw = wr_addr_q.size(); br = rd_addr_q.size();
        send(6'b001010, 3'b001, 3'b000, 3'b010, 5'd4, 5'd12, 5'd8, 64'd0);
        wait_resp(got, err);
        tests_run++;
        if (got !== 1'b1 || err !== 1'b0 || wr_addr_q.size() - bw != 4) begin
            tests_failed++;
            $display("FAIL lmul4_resp: resp=%b/%b writes=%0d want 1/0/4", got, err,
                     wr_addr_q.size() - bw);
        end
        for (int k = 0; k < 4; k++) begin
            exp_b = exp_t[k];
            tests_run++;
            if (wr_addr_q[bw+k] !== 5'(4 + k) || wr_data_q[bw+k] !== {16{exp_b}}) begin
                tests_failed++;
                $display("FAIL lmul4_write%0d: addr=%0d data=%h want %0d/%h", k, wr_addr_q[bw+k],
                         wr_data_q[bw+k], 4 + k, {16{exp_b}});
            end
            tests_run++;
            if (rd_addr_q[br+2*k] !== 5'(8 + k) || rd_addr_q[br+2*k+1] !== 5'(12 + k)) begin
                tests_failed++;
                $display("FAIL lmul4_read%0d: got %0d,%0d want %0d,%0d", k, rd_addr_q[br+2*k],
                         rd_addr_q[br+2*k+1], 8 + k, 12 + k);
            end
        end
    endtask

    task automatic test_errors;
        int bw, br, brun;
        logic [5:0] op;
        logic [2:0] ty, sew, lmul;
        logic [4:0] vd, v1;
        for (int t = 0; t < 5; t++) begin
            op = 6'b000000; ty = 3'b001; sew = 3'b000; lmul = 3'b000; vd = 5'd0; v1 = 5'd0;
            case (t)
                0: begin lmul = 3'b001; vd = 5'd3; end
                1: sew = 3'b100;
                2: op = 6'b000001;
                3: ty = 3'b011;
                4: begin lmul = 3'b001; v1 = 5'd1; end
                default: ;
            endcase
            #1;
            bw = wr_addr_q.size(); br = rd_addr_q.size(); brun = run_starts;
            send(op, ty, sew, lmul, vd, v1, 5'd0, 64'd0);
            tests_run++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
                tests_failed++;
                $display("FAIL err%0d_resp: valid=%b err=%b want 1/1", t, resp_valid, resp_err);
            end
            repeat (3) @(negedge clk);
            #1;
            tests_run++;
            if (wr_addr_q.size() != bw || rd_addr_q.size() != br || run_starts != brun ||
                req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL err%0d_quiet: wr=%0d rd=%0d run=%0d ready=%b want 0/0/0/1", t,
                         wr_addr_q.size() - bw, rd_addr_q.size() - br, run_starts - brun, req_ready);
            end
        end
    endtask

    task automatic test_reset_mid;
        int bw, bresp, brun;
        lane_delay = 6;
        vrf_set(5'd18, {16{8'h01}}); vrf_set(5'd19, {16{8'h02}});
        vrf_set(5'd20, {16{8'h03}}); vrf_set(5'd21, {16{8'h04}});
        #1;
        bw = wr_addr_q.size(); bresp = resp_count; brun = run_starts;
        send(6'b000000, 3'b001, 3'b000, 3'b001, 5'd16, 5'd20, 5'd18, 64'd0);
        for (int c = 0; c < 300 && run_starts < brun + 2; c++) @(negedge clk);
        tests_run++;
        if (run_starts < brun + 2) begin
            tests_failed++;
            $display("FAIL rmid_second_exec: runs=%0d want 2", run_starts - brun);
        end
        resetn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, rd_en, wr_en, alu_run} !== 5'b10000 || alu_vs2 !== '0 ||
            rd_addr !== 5'd0) begin
            tests_failed++;
            $display("FAIL rmid_outputs: ctrl=%b rd_addr=%0d want 10000/0",
                     {req_ready, resp_valid, rd_en, wr_en, alu_run}, rd_addr);
        end
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        tests_run++;
        if (wr_addr_q.size() - bw != 1 || wr_addr_q[bw] !== 5'd16 || resp_count != bresp) begin
            tests_failed++;
            $display("FAIL rmid_no_write: writes=%0d resp=%0d want 1/0", wr_addr_q.size() - bw,
                     resp_count - bresp);
        end
    endtask

    // In-place VX on a two-register group; vs1 misalignment is irrelevant for VX.
    task automatic test_overlap;
        int bw;
        logic got, err;
        lane_delay = 1;
        vrf_set(5'd4, {16{8'h05}});
        vrf_set(5'd5, {16{8'hFE}});
        bw = wr_addr_q.size();
        send(6'b000000, 3'b010, 3'b000, 3'b001, 5'd4, 5'd1, 5'd4, 64'h01);
        wait_resp(got, err);
        tests_run++;
        if (got !== 1'b1 || err !== 1'b0 || wr_addr_q.size() - bw != 2) begin
            tests_failed++;
            $display("FAIL ovl_resp: resp=%b/%b writes=%0d want 1/0/2", got, err, wr_addr_q.size() - bw);
        end
        tests_run++;
        if (wr_addr_q[bw] !== 5'd4 || wr_data_q[bw] !== {16{8'h06}} ||
            wr_addr_q[bw+1] !== 5'd5 || wr_data_q[bw+1] !== {16{8'hFF}}) begin
            tests_failed++;
            $display("FAIL ovl_data: %0d:%h %0d:%h want 4:06.. 5:FF..", wr_addr_q[bw], wr_data_q[bw],
                     wr_addr_q[bw+1], wr_data_q[bw+1]);
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; pre_en = 1'b0; pre_addr = 5'd0; pre_data = '0;
        req_opcode = 6'd0; req_op_type = 3'd0; req_vsew = 3'd0; req_vlmul = 3'd0;
        req_vd = 5'd0; req_vs1 = 5'd0; req_vs2 = 5'd0; req_scalar = 64'd0; lane_delay = 1;
        test_reset;
        test_vv_vadd;
        test_vx_vxor;
        test_vi_vand;
        test_lmul4;
        test_errors;
        test_reset_mid;
        test_overlap;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
